// File: rtl/htif_pkg.sv
// HTIF shared definitions: command codes, link constants and packet lengths.
// Used by both the off-chip master and the on-chip endpoint.
package htif_pkg;

    typedef enum logic [2:0] {
        CMD_RD_MEM = 3'd0,
        CMD_WR_MEM = 3'd1,
        CMD_RD_CR  = 3'd2,
        CMD_WR_CR  = 3'd3,
        CMD_START  = 3'd4,
        CMD_STOP   = 3'd5
    } htif_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } htif_state_e;

    typedef enum logic [1:0] {
        STS_OK      = 2'd0,
        STS_BADHDR  = 2'd1,
        STS_TIMEOUT = 2'd2,
        STS_BADCMD  = 2'd3
    } htif_status_e;

    localparam logic [7:0] HTIF_ACK = 8'h06;

    localparam logic [5:0] TXLEN_RD_MEM = 6'd10;
    localparam logic [5:0] TXLEN_WR_MEM = 6'd42;
    localparam logic [5:0] TXLEN_RD_CR  = 6'd10;
    localparam logic [5:0] TXLEN_WR_CR  = 6'd18;
    localparam logic [5:0] TXLEN_START  = 6'd10;
    localparam logic [5:0] TXLEN_STOP   = 6'd2;

    localparam logic [5:0] RXLEN_RD_MEM = 6'd34;
    localparam logic [5:0] RXLEN_RD_CR  = 6'd10;
    localparam logic [5:0] RXLEN_OTHER  = 6'd2;

    function automatic logic [5:0] tx_len(input logic [2:0] cmd);
        logic [5:0] n;
        n = TXLEN_STOP;
        case (cmd)
            CMD_RD_MEM: n = TXLEN_RD_MEM;
            CMD_WR_MEM: n = TXLEN_WR_MEM;
            CMD_RD_CR:  n = TXLEN_RD_CR;
            CMD_WR_CR:  n = TXLEN_WR_CR;
            CMD_START:  n = TXLEN_START;
            default:    n = TXLEN_STOP;
        endcase
        return n;
    endfunction

    function automatic logic [5:0] rx_len(input logic [2:0] cmd);
        logic [5:0] n;
        n = RXLEN_OTHER;
        case (cmd)
            CMD_RD_MEM: n = RXLEN_RD_MEM;
            CMD_RD_CR:  n = RXLEN_RD_CR;
            default:    n = RXLEN_OTHER;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/htif_nibble_deser.sv
// RX nibble deserializer: counts received nibbles, checks the ack header
// and assembles the payload LS nibble first.
module htif_nibble_deser
    import htif_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         acc_i,
    input  logic [3:0]   nib_i,
    input  logic [5:0]   len_i,
    output logic         last_o,
    output logic         bad_o,
    output logic [127:0] data_o
);

    logic [5:0]   cnt_q;
    logic [3:0]   lo_q;
    logic [127:0] data_q;
    logic [4:0]   di;

    assign di     = 5'(cnt_q - 6'd2);
    assign bad_o  = acc_i && (cnt_q == 6'd1) && ({nib_i, lo_q} != HTIF_ACK);
    assign last_o = acc_i && !bad_o && (cnt_q == len_i - 6'd1);
    assign data_o = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            lo_q   <= '0;
            data_q <= '0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            lo_q   <= '0;
            data_q <= '0;
        end else if (acc_i) begin
            if (cnt_q == 6'd0)
                lo_q <= nib_i;
            if (cnt_q >= 6'd2)
                data_q[{di, 2'b00} +: 4] <= nib_i;
            // Counter parks on the final nibble rather than wrapping.
            if (!last_o && !bad_o)
                cnt_q <= cnt_q + 6'd1;
        end
    end

endmodule

// File: rtl/htif_offchip_master.sv
// HTIF off-chip master: serialises a command packet to the chip over a
// 4-bit link, then collects and checks the reply.
module htif_offchip_master
    import htif_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_val,
    output logic         req_rdy,
    input  logic [2:0]   req_cmd,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_data,
    output logic         resp_val,
    input  logic         resp_rdy,
    output logic [1:0]   resp_status,
    output logic [127:0] resp_data,
    output logic         tx_val,
    output logic [3:0]   tx_bits,
    input  logic         tx_rdy,
    input  logic         rx_val,
    input  logic [3:0]   rx_bits,
    output logic         rx_rdy,
    output logic         busy
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    htif_state_e  state_q;
    logic [2:0]   cmd_q;
    logic [167:0] tx_q;
    logic [5:0]   nib_q;
    logic [15:0]  idle_q;
    logic [1:0]   sts_q;
    logic         rdy_q;

    logic         req_acc;
    logic         tx_acc;
    logic         rx_acc;
    logic         rx_last;
    logic         rx_bad;
    logic [127:0] rx_data;

    assign req_acc = (state_q == ST_IDLE) && req_val && rdy_q;
    assign tx_acc  = tx_val && tx_rdy;
    assign rx_acc  = rx_val && rx_rdy;

    assign req_rdy     = rdy_q;
    assign tx_val      = (state_q == ST_SEND);
    assign tx_bits     = tx_q[3:0];
    assign rx_rdy      = (state_q == ST_RECV);
    assign resp_val    = (state_q == ST_DONE);
    assign resp_status = sts_q;
    assign resp_data   = rx_data;
    assign busy        = (state_q != ST_IDLE);

    htif_nibble_deser u_deser (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (req_acc),
        .acc_i  (rx_acc),
        .nib_i  (rx_bits),
        .len_i  (rx_len(cmd_q)),
        .last_o (rx_last),
        .bad_o  (rx_bad),
        .data_o (rx_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            tx_q    <= '0;
            nib_q   <= '0;
            idle_q  <= '0;
            sts_q   <= STS_OK;
            rdy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    rdy_q <= 1'b1;
                    if (req_acc) begin
                        rdy_q <= 1'b0;
                        cmd_q <= req_cmd;
                        nib_q <= '0;
                        if (req_cmd > 3'd5) begin
                            state_q <= ST_DONE;
                            sts_q   <= STS_BADCMD;
                        end else begin
                            state_q <= ST_SEND;
                            sts_q   <= STS_OK;
                            tx_q    <= {req_data, req_addr, 5'b0, req_cmd};
                        end
                    end
                end
                ST_SEND: begin
                    if (tx_acc) begin
                        if (nib_q == tx_len(cmd_q) - 6'd1) begin
                            state_q <= ST_RECV;
                            nib_q   <= '0;
                            idle_q  <= '0;
                            tx_q    <= '0;
                        end else begin
                            nib_q <= nib_q + 6'd1;
                            tx_q  <= tx_q >> 4;
                        end
                    end
                end
                ST_RECV: begin
                    if (rx_bad) begin
                        state_q <= ST_DONE;
                        sts_q   <= STS_BADHDR;
                    end else if (rx_last) begin
                        state_q <= ST_DONE;
                        sts_q   <= STS_OK;
                    end else if (rx_acc) begin
                        idle_q <= '0;
                    end else if (idle_q == TO_LAST) begin
                        state_q <= ST_DONE;
                        sts_q   <= STS_TIMEOUT;
                    end else begin
                        idle_q <= idle_q + 16'd1;
                    end
                end
                ST_DONE: begin
                    if (resp_rdy) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_htif_offchip_master.sv
// Directed bench for htif_offchip_master: packet framing, handshakes,
// header errors, timeout, reset abort and illegal commands.
module tb_htif_offchip_master;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_val = 1'b0;
    logic         req_rdy;
    logic [2:0]   req_cmd = '0;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_data = '0;
    logic         resp_val;
    logic         resp_rdy = 1'b0;
    logic [1:0]   resp_status;
    logic [127:0] resp_data;
    logic         tx_val;
    logic [3:0]   tx_bits;
    logic         tx_rdy = 1'b0;
    logic         rx_val = 1'b0;
    logic [3:0]   rx_bits = '0;
    logic         rx_rdy;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit tx_seen = 1'b0;

    htif_offchip_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_status (resp_status),
        .resp_data   (resp_data),
        .tx_val      (tx_val),
        .tx_bits     (tx_bits),
        .tx_rdy      (tx_rdy),
        .rx_val      (rx_val),
        .rx_bits     (rx_bits),
        .rx_rdy      (rx_rdy),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tx_val) tx_seen = 1'b1;

    task automatic chk(input string tag, input logic [167:0] got,
                       input logic [167:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [2:0] c, input logic [31:0] a,
                          input logic [127:0] d);
        int k = 0;
        while (!req_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("req_rdy_wait", 168'(req_rdy), 168'(1));
        req_val  = 1'b1;
        req_cmd  = c;
        req_addr = a;
        req_data = d;
        @(negedge clk);
        req_val = 1'b0;
    endtask

    task automatic collect_tx(input int n, input bit tog,
                              output logic [167:0] s);
        int got = 0;
        int k = 0;
        s = '0;
        while (got < n && k < 400) begin
            tx_rdy = tog ? ((k % 2) == 0) : 1'b1;
            if (tx_val && tx_rdy) begin
                s[4*got +: 4] = tx_bits;
                got++;
            end
            @(negedge clk);
            k++;
        end
        tx_rdy = 1'b0;
        chk("tx_count", 168'(got), 168'(n));
    endtask

    task automatic send_rx(input logic [3:0] nibs[], input int n);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            rx_val  = 1'b1;
            rx_bits = nibs[i];
            while (!rx_rdy && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (!rx_rdy) chk("rx_rdy_wait", 168'(rx_rdy), 168'(1));
            @(negedge clk);
        end
        rx_val = 1'b0;
    endtask

    task automatic wait_resp(output logic [1:0] s, output logic [127:0] d,
                             output int k);
        k = 0;
        while (!resp_val && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("resp_val", 168'(resp_val), 168'(1));
        s = resp_status;
        d = resp_data;
        @(negedge clk);
        chk("hold_val", 168'(resp_val), 168'(1));
        chk("hold_data", 168'(resp_data), 168'(d));
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        chk("resp_clr", 168'(resp_val), 168'(0));
        chk("idle_rdy", 168'(req_rdy), 168'(1));
    endtask

    initial begin
        logic [167:0] s;
        logic [1:0]   st;
        logic [127:0] d;
        int           k;
        logic [3:0]   r1[] = '{4'h6, 4'h0, 4'h8, 4'h7, 4'h6,
                               4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        logic [3:0]   rok[] = '{4'h6, 4'h0};
        logic [3:0]   rbad[] = '{4'h7, 4'h0};
        logic [3:0]   rto[] = '{4'h6, 4'h0, 4'hA};

        repeat (3) @(negedge clk);
        chk("rst_req_rdy", 168'(req_rdy), 168'(0));
        chk("rst_tx_val", 168'(tx_val), 168'(0));
        chk("rst_rx_rdy", 168'(rx_rdy), 168'(0));
        chk("rst_resp", 168'({resp_val, busy, resp_status}), 168'(0));
        chk("rst_data", 168'(resp_data), 168'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req_rdy", 168'(req_rdy), 168'(1));

        // rd_cr
        do_req(3'd2, 32'h0001_0000, '0);
        chk("t1_busy", 168'(busy), 168'(1));
        collect_tx(10, 1'b0, s);
        chk("t1_tx", s, 168'h00010000_02);
        chk("t1_recv", 168'({tx_val, rx_rdy}), 168'(2'b01));
        send_rx(r1, 10);
        wait_resp(st, d, k);
        chk("t1_sts", 168'(st), 168'(0));
        chk("t1_data", 168'(d), 168'h12345678);

        // wr_mem with throttled tx_rdy
        do_req(3'd1, 32'h100, 128'h0123456789ABCDEF_0123456789ABCDEF);
        collect_tx(42, 1'b1, s);
        chk("t2_tx", s,
            {128'h0123456789ABCDEF_0123456789ABCDEF, 32'h100, 8'h01});
        send_rx(rok, 2);
        wait_resp(st, d, k);
        chk("t2_sts", 168'(st), 168'(0));
        chk("t2_data", 168'(d), 168'(0));

        // stop with bad header
        do_req(3'd5, 32'hDEAD_BEEF, '0);
        collect_tx(2, 1'b0, s);
        chk("t3_tx", s, 168'h05);
        send_rx(rbad, 2);
        chk("t3_no_rx", 168'(rx_rdy), 168'(0));
        wait_resp(st, d, k);
        chk("t3_sts", 168'(st), 168'(1));
        chk("t3_data", 168'(d), 168'(0));

        // rd_mem, chip goes silent after three nibbles
        do_req(3'd0, 32'h8000_0010, '0);
        collect_tx(10, 1'b0, s);
        chk("t4_tx", s, {32'h80000010, 8'h00});
        send_rx(rto, 3);
        k = 0;
        while (!resp_val && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t4_idle_cycles", 168'(k), 168'(16));
        wait_resp(st, d, k);
        chk("t4_sts", 168'(st), 168'(2));
        chk("t4_data", 168'(d), 168'hA);

        // reset in the middle of a wr_mem packet
        do_req(3'd1, 32'h200, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000);
        collect_tx(20, 1'b0, s);
        chk("t5_pre_tx_val", 168'(tx_val), 168'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_tx_val", 168'(tx_val), 168'(0));
        chk("t5_tx_bits", 168'(tx_bits), 168'(0));
        chk("t5_req_rdy", 168'(req_rdy), 168'(0));
        chk("t5_busy", 168'({busy, resp_val}), 168'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_rdy_held", 168'(req_rdy), 168'(0));
        @(negedge clk);
        chk("t5_rdy_rel", 168'(req_rdy), 168'(1));
        chk("t5_no_resp", 168'(resp_val), 168'(0));

        // illegal command
        tx_seen = 1'b0;
        do_req(3'd7, 32'h0, 128'h55);
        k = 0;
        while (!resp_val && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("t6_latency", 168'(k <= 1), 168'(1));
        wait_resp(st, d, k);
        chk("t6_sts", 168'(st), 168'(3));
        chk("t6_data", 168'(d), 168'(0));
        chk("t6_no_tx", 168'(tx_seen), 168'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
